// File: rtl/friscv_ctrl_fsm.sv
// friscv_ctrl_fsm: multi-cycle fetch/decode/execute/mem/writeback sequencer with traps and retire counter
module friscv_ctrl_fsm #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  output logic                 imem_req_out,
  input  logic                 imem_ack_in,
  output logic                 ir_load_out,
  input  logic [6:0]           op_code_in,
  input  logic [2:0]           func3_in,
  input  logic                 instr30_in,
  input  logic                 branch_taken_in,
  output logic                 dmem_req_out,
  output logic                 dmem_we_out,
  input  logic                 dmem_ack_in,
  output logic                 alu_src_imm_out,
  output logic [3:0]           alu_func_out,
  output logic [1:0]           wb_sel_out,
  output logic                 rf_we_out,
  output logic                 pc_we_out,
  output logic [1:0]           pc_sel_out,
  output logic                 illegal_instr_out,
  output logic                 bus_err_out,
  output logic [2:0]           state_out,
  output logic [CNT_WIDTH-1:0] instret_out
);
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  state_t state, state_nx;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic       i30_q;
  logic [7:0] tmo_cnt;
  logic       legal, waiting, ack, tmo, ex, wb;
  logic [3:0] alu_func;
  always_comb begin
    legal    = op_code_in inside {OP_REG, OP_IMM, OP_JALR, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL};
    waiting  = state == FETCH || state == MEM;
    ack      = state == FETCH ? imem_ack_in : dmem_ack_in;
    tmo      = tmo_cnt == 8'(TIMEOUT_CYCLES);
    state_nx = state;
    case (state)
      FETCH:     state_nx = imem_ack_in ? DECODE : tmo ? TRAP : FETCH;
      DECODE:    state_nx = legal ? EXECUTE : TRAP;
      EXECUTE:   state_nx = (op_q == OP_LOAD || op_q == OP_STORE) ? MEM : WRITEBACK;
      MEM:       state_nx = dmem_ack_in ? WRITEBACK : tmo ? TRAP : MEM;
      WRITEBACK: state_nx = FETCH;
      TRAP:      state_nx = TRAP;
      default:   state_nx = TRAP;
    endcase
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= FETCH;
      tmo_cnt           <= '0;
      instret_out       <= '0;
      illegal_instr_out <= 1'b0;
      bus_err_out       <= 1'b0;
      op_q              <= '0;
      f3_q              <= '0;
      i30_q             <= 1'b0;
    end else begin
      state   <= state_nx;
      tmo_cnt <= state_nx != state ? 8'd0 : (waiting && !ack) ? tmo_cnt + 8'd1 : tmo_cnt;
      if (state == DECODE) begin
        op_q  <= op_code_in;
        f3_q  <= func3_in;
        i30_q <= instr30_in;
      end
      if (state == WRITEBACK) instret_out <= instret_out + 1'b1;
      if (state == DECODE && !legal) illegal_instr_out <= 1'b1;
      if (waiting && !ack && tmo) bus_err_out <= 1'b1;
    end
  end
  always_comb begin
    ex              = state == EXECUTE || state == MEM || state == WRITEBACK;
    wb              = state == WRITEBACK;
    alu_func        = op_q == OP_REG ? {i30_q, f3_q} :
                      op_q == OP_IMM ? {i30_q && f3_q == 3'b101, f3_q} : 4'b0000;
    imem_req_out    = state == FETCH && !rst_in;
    ir_load_out     = imem_req_out && imem_ack_in;
    dmem_req_out    = state == MEM;
    dmem_we_out     = state == MEM && op_q == OP_STORE;
    alu_func_out    = ex ? alu_func : 4'b0000;
    alu_src_imm_out = ex && op_q != OP_REG && op_q != OP_BRANCH;
    rf_we_out       = wb && op_q != OP_BRANCH && op_q != OP_STORE;
    pc_we_out       = wb;
    wb_sel_out      = !wb ? 2'd0 : op_q == OP_LOAD ? 2'd1 :
                      (op_q == OP_JAL || op_q == OP_JALR) ? 2'd2 : op_q == OP_LUI ? 2'd3 : 2'd0;
    pc_sel_out      = !wb ? 2'd0 : op_q == OP_JAL ? 2'd1 : op_q == OP_JALR ? 2'd2 :
                      (op_q == OP_BRANCH && branch_taken_in) ? 2'd1 : 2'd0;
    state_out       = state;
  end
endmodule

// File: tb/tb_friscv_ctrl_fsm.sv
// tb_friscv_ctrl_fsm: randomized instruction streams checked cycle by cycle against an instruction-level model
module tb_friscv_ctrl_fsm;
  localparam int TO = 15;
  localparam int CW = 4;
  logic clk_in = 1'b0, rst_in = 1'b1;
  logic imem_ack_in = 1'b0, dmem_ack_in = 1'b0, instr30_in = 1'b0, branch_taken_in = 1'b0;
  logic [6:0] op_code_in = '0;
  logic [2:0] func3_in = '0;
  logic imem_req_out, ir_load_out, dmem_req_out, dmem_we_out, alu_src_imm_out;
  logic rf_we_out, pc_we_out, illegal_instr_out, bus_err_out;
  logic [3:0] alu_func_out;
  logic [1:0] wb_sel_out, pc_sel_out;
  logic [2:0] state_out;
  logic [CW-1:0] instret_out;
  int tests = 0, fails = 0;
  logic [CW-1:0] exp_ret = '0;
  logic [6:0] ops [8] = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F};
  typedef struct packed {
    logic mem, store;
    logic [3:0] af;
    logic simm, rfwe;
    logic [1:0] wbsel, pcsel;
  } ctrl_t;
  logic [17:0] obs;
  logic [19+CW:0] full;
  always #5 clk_in = ~clk_in;
  assign obs  = {state_out, imem_req_out, ir_load_out, dmem_req_out, dmem_we_out, alu_src_imm_out,
                 alu_func_out, wb_sel_out, rf_we_out, pc_we_out, pc_sel_out};
  assign full = {obs, illegal_instr_out, bus_err_out, instret_out};
  friscv_ctrl_fsm #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .imem_req_out(imem_req_out), .imem_ack_in(imem_ack_in),
    .ir_load_out(ir_load_out), .op_code_in(op_code_in), .func3_in(func3_in), .instr30_in(instr30_in),
    .branch_taken_in(branch_taken_in), .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
    .dmem_ack_in(dmem_ack_in), .alu_src_imm_out(alu_src_imm_out), .alu_func_out(alu_func_out),
    .wb_sel_out(wb_sel_out), .rf_we_out(rf_we_out), .pc_we_out(pc_we_out), .pc_sel_out(pc_sel_out),
    .illegal_instr_out(illegal_instr_out), .bus_err_out(bus_err_out), .state_out(state_out),
    .instret_out(instret_out)
  );
  function automatic ctrl_t model(input logic [6:0] op, input logic [2:0] f3, input logic i30, input logic bt);
    ctrl_t c;
    c = '0;
    case (op)
      7'h33: begin c.af = {i30, f3}; c.rfwe = 1; end
      7'h13: begin c.af = {i30 && f3 == 3'd5, f3}; c.simm = 1; c.rfwe = 1; end
      7'h03: begin c.mem = 1; c.simm = 1; c.rfwe = 1; c.wbsel = 2'd1; end
      7'h23: begin c.mem = 1; c.store = 1; c.simm = 1; end
      7'h63: c.pcsel = bt ? 2'd1 : 2'd0;
      7'h37: begin c.simm = 1; c.rfwe = 1; c.wbsel = 2'd3; end
      7'h6F: begin c.simm = 1; c.rfwe = 1; c.wbsel = 2'd2; c.pcsel = 2'd1; end
      7'h67: begin c.simm = 1; c.rfwe = 1; c.wbsel = 2'd2; c.pcsel = 2'd2; end
      default: c = '0;
    endcase
    return c;
  endfunction
  function automatic logic [17:0] expv(input int s, input bit ack, input ctrl_t c);
    logic ex, wb;
    ex = s >= 2 && s <= 4;
    wb = s == 4;
    return {3'(s), s == 0, s == 0 && ack, s == 3, s == 3 && c.store, ex && c.simm, ex ? c.af : 4'd0,
            wb ? c.wbsel : 2'd0, wb && c.rfwe, wb, wb ? c.pcsel : 2'd0};
  endfunction
  task automatic do_reset;
    rst_in = 1'b1;
    imem_ack_in = 1'b0;
    dmem_ack_in = 1'b0;
    exp_ret = '0;
    @(negedge clk_in);
    tests++;
    if (full !== '0) begin fails++; $display("FAIL reset: got %b want all zero", full); end
    @(posedge clk_in);
    #1 rst_in = 1'b0;
  endtask
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic i30, input logic bt,
                           input int iw, input int dw, input bit stray);
    ctrl_t c;
    int nm, total, s;
    logic [19+CW:0] e;
    c = model(op, f3, i30, bt);
    nm = c.mem ? dw + 1 : 0;
    total = iw + 4 + nm;
    op_code_in = op;
    func3_in = f3;
    instr30_in = i30;
    branch_taken_in = bt;
    for (int k = 0; k < total; k++) begin
      s = k <= iw ? 0 : k == iw + 1 ? 1 : k == iw + 2 ? 2 : k < iw + 3 + nm ? 3 : 4;
      imem_ack_in = s == 0 ? k == iw : stray && $urandom_range(1) == 1;
      dmem_ack_in = s == 3 ? k - (iw + 3) == dw : stray && $urandom_range(1) == 1;
      e = {expv(s, k == iw, c), 2'b00, exp_ret};
      @(negedge clk_in);
      tests++;
      if (full !== e) begin
        fails++;
        $display("FAIL instr op=%h f3=%0d k=%0d: got %b want %b", op, f3, k, full, e);
      end
      @(posedge clk_in);
      #1;
    end
    imem_ack_in = 1'b0;
    dmem_ack_in = 1'b0;
    exp_ret++;
    tests++;
    if (instret_out !== exp_ret) begin fails++; $display("FAIL instret: got %0d want %0d", instret_out, exp_ret); end
  endtask
  task automatic test_reset;
    do_reset;
    @(negedge clk_in);
    tests++;
    if (full !== {expv(0, 0, '0), 2'b00, exp_ret}) begin
      fails++; $display("FAIL post_reset_req: got %b want %b", full, {expv(0, 0, '0), 2'b00, exp_ret});
    end
    @(posedge clk_in);
    #1;
  endtask
  task automatic test_add;
    do_reset;
    run_instr(7'h33, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask
  task automatic test_lw;
    run_instr(7'h03, 3'd2, 1'b0, 1'b0, 0, 3, 1'b0);
  endtask
  task automatic test_branch;
    run_instr(7'h63, 3'd0, 1'b0, 1'b1, 0, 0, 1'b0);
    run_instr(7'h63, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask
  task automatic test_random;
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(7)], 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(TO), $urandom_range(TO), 1'b1);
  endtask
  task automatic test_illegal;
    logic [19+CW:0] e;
    do_reset;
    op_code_in = 7'h7F;
    for (int k = 0; k < 12; k++) begin
      imem_ack_in = k == 0 ? 1'b1 : $urandom_range(1) == 1;
      dmem_ack_in = $urandom_range(1) == 1;
      e = k == 0 ? {expv(0, 1, '0), 2'b00, exp_ret} : k == 1 ? {expv(1, 0, '0), 2'b00, exp_ret} :
                   {expv(5, 0, '0), 2'b10, exp_ret};
      @(negedge clk_in);
      tests++;
      if (full !== e) begin fails++; $display("FAIL illegal k=%0d: got %b want %b", k, full, e); end
      @(posedge clk_in);
      #1;
    end
  endtask
  task automatic test_timeout;
    logic [19+CW:0] e;
    ctrl_t c;
    do_reset;
    for (int k = 0; k <= TO + 1; k++) begin
      imem_ack_in = 1'b0;
      dmem_ack_in = $urandom_range(1) == 1;
      e = k <= TO ? {expv(0, 0, '0), 2'b00, exp_ret} : {expv(5, 0, '0), 2'b01, exp_ret};
      @(negedge clk_in);
      tests++;
      if (full !== e) begin fails++; $display("FAIL imem_timeout k=%0d: got %b want %b", k, full, e); end
      @(posedge clk_in);
      #1;
    end
    do_reset;
    run_instr(7'h33, 3'd0, 1'b0, 1'b0, TO, 0, 1'b0);
    do_reset;
    c = model(7'h03, 3'd2, 1'b0, 1'b0);
    op_code_in = 7'h03;
    func3_in = 3'd2;
    for (int k = 0; k < TO + 5; k++) begin
      imem_ack_in = k == 0 ? 1'b1 : $urandom_range(1) == 1;
      dmem_ack_in = 1'b0;
      e = k < 3 ? {expv(k, k == 0, c), 2'b00, exp_ret} :
          k < TO + 4 ? {expv(3, 0, c), 2'b00, exp_ret} : {expv(5, 0, c), 2'b01, exp_ret};
      @(negedge clk_in);
      tests++;
      if (full !== e) begin fails++; $display("FAIL dmem_timeout k=%0d: got %b want %b", k, full, e); end
      @(posedge clk_in);
      #1;
    end
  endtask
  task automatic test_reset_mid_mem;
    do_reset;
    run_instr(7'h33, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0);
    op_code_in = 7'h23;
    func3_in = 3'd2;
    for (int k = 0; k < 3; k++) begin
      imem_ack_in = k == 0;
      dmem_ack_in = 1'b0;
      @(posedge clk_in);
      #1;
    end
    @(negedge clk_in);
    tests++;
    if ({dmem_req_out, dmem_we_out, state_out} !== 5'b11011) begin
      fails++; $display("FAIL sw_mem: got %b want 11011", {dmem_req_out, dmem_we_out, state_out});
    end
    #2 rst_in = 1'b1;
    #1;
    tests++;
    if ({dmem_req_out, state_out, instret_out} !== '0) begin
      fails++; $display("FAIL async_reset: got %b want 0", {dmem_req_out, state_out, instret_out});
    end
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    exp_ret = '0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_add;
    test_lw;
    test_branch;
    test_random;
    test_illegal;
    test_timeout;
    test_reset_mid_mem;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
